// File: rtl/types_pkg.sv
// Shared types and constants for the CHIP-8 program-counter sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package types;

    typedef logic        [15:0] u16;
    typedef logic signed [15:0] i16;

    // Sticky stack fault code reported by the sequencer
    typedef enum logic [1:0] {
        NONE = 2'b00,
        OVF  = 2'b01,
        UNF  = 2'b10
    } pc_fault_e;

    // Fault FSM: RUN executes requests, HALT freezes the PC until reset
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } seq_state_e;

    // Low memory holds the font sprites followed by the legacy stack area;
    // programs start right after both.
    localparam int FONT_BYTES         = 80;
    localparam int LEGACY_STACK_BYTES = 32;
    localparam int DEFAULT_RESET_PC   = FONT_BYTES + LEGACY_STACK_BYTES;

endpackage

// File: rtl/return_stack.sv
// Return-address stack: register array with push/pop, combinational top, depth, full/empty.
// Latency: push/pop take effect at the next edge; top and depth are read combinationally.
// Backpressure: none; push when full overwrites the top entry, pop when empty is ignored.
module return_stack #(
    parameter int  STACK_DEPTH = 16,
    parameter int  PC_W        = 16,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1),
    localparam int IDX_W       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [PC_W-1:0]    push_dat_i,
    output logic [PC_W-1:0]    top_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               full_o,
    output logic               empty_o
);

    logic [PC_W-1:0]    mem_q [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [IDX_W-1:0]   wr_idx, rd_idx;

    assign full_o  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty_o = (depth_q == '0);

    // A push on a full stack lands on the last slot instead of growing
    assign wr_idx  = full_o ? IDX_W'(STACK_DEPTH - 1) : IDX_W'(depth_q);
    assign rd_idx  = IDX_W'(depth_q - 1'b1);
    assign top_o   = mem_q[rd_idx];
    assign depth_o = depth_q;

    // Depth saturates at both ends
    always_comb begin
        depth_d = depth_q;
        if (push_i && !full_o) begin
            depth_d = depth_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            depth_d = depth_q - 1'b1;
        end
    end

    // Depth register; entries themselves need no reset
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_idx] <= push_dat_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// CHIP-8 program counter: advance, skip, branch, relative offset, call/return with stack.
// Latency: one cycle from sampled request to program_counter/stack_depth.
// Backpressure: stalled holds advance/skip only; PC_SEQ_STACK_FAULT_EN adds a sticky fault halt.
module pc_sequencer
    import types::*;
#(
    parameter int  PC_W        = 16,
    parameter int  RESET_PC    = DEFAULT_RESET_PC,
    parameter int  STACK_DEPTH = 16,
    parameter int  INSTR_BYTES = 2,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stalled,
    input  logic               branching,
    input  logic [PC_W-1:0]    branch,
    input  logic               offsetting,
    input  logic [PC_W-1:0]    offset,
    input  logic               calling,
    input  logic               returning,
    input  logic               skipping,
    output logic [PC_W-1:0]    program_counter,
    output logic [DEPTH_W-1:0] stack_depth,
    output logic               fault,
    output logic [1:0]         fault_code
);

    localparam logic [PC_W-1:0] INC    = PC_W'(INSTR_BYTES);
    localparam logic [PC_W-1:0] INC2   = PC_W'(2 * INSTR_BYTES);
    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            halt, fault_hit;
    logic            do_branch, do_call, do_ret, do_off, do_skip, do_adv;
    logic            stk_push, stk_pop, stk_full, stk_empty;
    logic [PC_W-1:0] stk_top;

    // One-hot priority decode: only the winning request may act
    assign do_branch = !halt && branching;
    assign do_call   = !halt && !branching && calling;
    assign do_ret    = !halt && !branching && !calling && returning;
    assign do_off    = !halt && !branching && !calling && !returning && offsetting;
    assign do_skip   = !halt && !branching && !calling && !returning && !offsetting
                       && skipping && !stalled;
    assign do_adv    = !halt && !branching && !calling && !returning && !offsetting
                       && !skipping && !stalled;

`ifdef PC_SEQ_STACK_FAULT_EN
    seq_state_e state_q, state_d;
    pc_fault_e  code_q, code_d;
    logic       ovf, unf;

    assign halt      = (state_q == HALT);
    assign ovf       = do_call && stk_full;
    assign unf       = do_ret && stk_empty;
    assign fault_hit = ovf || unf;

    // Fault state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            code_q  <= NONE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    // First stack fault latches its code and halts until reset
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            RUN: begin
                if (fault_hit) begin
                    state_d = HALT;
                    code_d  = ovf ? OVF : UNF;
                end
            end
            HALT: state_d = HALT;
        endcase
    end

    assign fault      = halt;
    assign fault_code = code_q;
`else
    logic unused_full;

    assign halt        = 1'b0;
    assign fault_hit   = 1'b0;
    assign fault       = 1'b0;
    assign fault_code  = NONE;
    assign unused_full = stk_full;
`endif

    // A faulting call/return leaves the stack untouched
    assign stk_push = do_call && !fault_hit;
    assign stk_pop  = do_ret && !fault_hit;

    return_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .PC_W        (PC_W)
    ) u_stack (
        .clk        (clk),
        .rst        (rst),
        .push_i     (stk_push),
        .pop_i      (stk_pop),
        .push_dat_i (pc_q + INC),
        .top_o      (stk_top),
        .depth_o    (stack_depth),
        .full_o     (stk_full),
        .empty_o    (stk_empty)
    );

    // Next-PC selection; all arithmetic wraps at PC_W bits
    always_comb begin
        pc_d = pc_q;
        if (fault_hit) begin
            pc_d = pc_q;
        end else if (do_branch || do_call) begin
            pc_d = branch;
        end else if (do_ret) begin
            pc_d = stk_empty ? RST_PC : stk_top;
        end else if (do_off) begin
            pc_d = pc_q + INC + offset;
        end else if (do_skip) begin
            pc_d = pc_q + INC2;
        end else if (do_adv) begin
            pc_d = pc_q + INC;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RST_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign program_counter = pc_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the CHIP-8 core, sitting in front of instruction fetch. It replaces the fixed 16-bit PC register. Beyond plain advance, absolute branch and relative offset, it adds:
- an internal call/return stack,
- a skip-next-instruction step,
- stack depth reporting,
- stack overflow/underflow fault detection.

## Interface
Parameters:
- PC_W, 16, program counter width in bits; all PC arithmetic is modulo 2^PC_W
- RESET_PC, 112, PC value loaded on reset (80 bytes of font sprites plus 32 bytes of legacy stack area)
- STACK_DEPTH, 16, number of return-address entries; must be ≥ 1
- INSTR_BYTES, 2, PC increment per instruction

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  reset; synchronous and active-high
- stalled  in  1  holds sequential advance and skip, e.g. while waiting on a keypress
- branching  in  1  absolute jump to `branch`
- branch  in  PC_W  jump or call target
- offsetting  in  1  relative jump
- offset  in  PC_W  two's-complement displacement
- calling  in  1  push return address, then jump to `branch`
- returning  in  1  pop return address into PC
- skipping  in  1  skip the next instruction
- program_counter  out  PC_W  current fetch address
- stack_depth  out  $clog2(STACK_DEPTH+1)  number of valid stack entries
- fault  out  1  sticky stack fault (present only when the macro is defined; otherwise tied 0)
- fault_code  out  2  01 = overflow, 10 = underflow, 00 = none

## Operation
- Priority, highest first: rst, fault halt, branching, calling, returning, offsetting, skipping, advance, hold.
- rst:
  - program_counter = RESET_PC
  - stack_depth = 0
  - fault = 0, fault_code = 00
  - stack contents are don't-care
- branching: PC ← branch.
- calling:
  - push (PC + INSTR_BYTES) at index stack_depth
  - depth +1
  - PC ← branch
- returning:
  - PC ← entry[stack_depth−1]
  - depth −1
- offsetting: PC ← PC + INSTR_BYTES + offset, truncated to PC_W bits.
- skipping, when !stalled: PC ← PC + 2·INSTR_BYTES.
- Advance, when !stalled: PC ← PC + INSTR_BYTES.
- Otherwise: hold.
- stalled gates only skip and advance. branching, calling, returning and offsetting take effect even while stalled.
- Only the highest-priority request acts. Lower-priority requests in the same cycle are dropped with no side effects; e.g. calling with branching asserted does not push.
- All additions wrap modulo 2^PC_W. There is no alignment enforcement.

## Timing
- Single-cycle: a request sampled at edge N is visible on program_counter and stack_depth after edge N.
- The return target is read combinationally from the stack top. There is no extra latency.
- A call followed by a return on the next cycle returns to the pushed address. This is back-to-back safe.
- Reset mid-sequence takes effect at the next edge and discards the whole stack.
- Full stack (depth == STACK_DEPTH) with calling: overflow; behaviour per Configuration.
- Empty stack (depth == 0) with returning: underflow; behaviour per Configuration.

## Configuration
Macro: PC_SEQ_STACK_FAULT_EN.

Defined:
- Overflow or underflow sets fault = 1 and latches fault_code.
- PC, depth and stack are not modified on the faulting cycle.
- Afterwards the PC is frozen; all requests are ignored until rst.

Undefined:
- fault and fault_code are tied 0.
- Overflow performs the jump, overwrites entry[STACK_DEPTH−1], and depth stays STACK_DEPTH.
- Underflow loads RESET_PC, and depth stays 0.

## Structure
- Package `types`:
  - u16/i16 stay as-is
  - add the fault-code enum `pc_fault_e` (NONE = 00, OVF = 01, UNF = 10)
  - add constants FONT_BYTES = 80 and LEGACY_STACK_BYTES = 32, so RESET_PC defaults to their sum
- Sub-module `return_stack`:
  - register array with push, pop, top and depth outputs
  - parameters STACK_DEPTH and PC_W
  - full and empty flags
- pc_sequencer holds the PC register, priority logic and fault FSM (RUN and HALT states).

## Test plan
- Reset: assert rst with stalled = 0 → PC = 112 and depth = 0 after the edge; 3 free cycles → 114, 116, 118.
- Stall vs branch: stalled = 1 for 2 cycles → PC holds; stalled = 1 with branching and branch = 0x300 → PC = 0x300 next cycle.
- Relative offset, PC = 0x200:
  - offset = −6 → PC = 0x1FC
  - with PC_W = 12, PC = 0xFFE and offset = 4 → PC = 0x004 (wrap)
- Call/return nesting: from PC = 0x200, call 0x400, then call 0x500 → depth = 2; return → PC = 0x402; return → PC = 0x202, depth = 0.
- Overflow, STACK_DEPTH = 2, macro defined:
  - third call → fault = 1, fault_code = 01, PC unchanged
  - subsequent branching is ignored until rst
- Underflow, macro undefined: return on an empty stack → PC = 112, depth = 0, fault = 0. Also skipping from 0x210 → 0x214.
